// File: rtl/mix_columns_stage.sv
// mix_columns_stage
// AES round-datapath stage that sits after ShiftRows. It applies MixColumns
// (encrypt) or InvMixColumns (decrypt) to a 128-bit state, or passes the state
// through unchanged for the final encrypt round. The datapath is a two-stage
// pipeline with valid/ready flow control on both sides.
//
// Byte layout: byte k of the state is the k-th byte counted from the most
// significant end of the 128-bit vector. In the hex notation used by FIPS-197,
// the first two digits are byte 0. Column c holds bytes 4c..4c+3, and row r of
// column c is byte 4c+r.
//
// Stage 1 registers each byte together with its xtime multiples (x2, x4, x8).
// Stage 2 combines those multiples into the column products and registers the
// result. The mode flags are registered next to the beat, so every beat keeps
// its own mode while it is in flight.

module mix_columns_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_enc_en,
  input  logic             in_bypass,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [CNT_W-1:0] blk_cnt
);

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial 0x11B
  // ---------------------------------------------------------------------------

  // Multiply by 2 in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // 3*a = 2*a ^ a
  function automatic logic [7:0] mul_03(input logic [7:0] b, input logic [7:0] x2);
    return x2 ^ b;
  endfunction

  // 9*a = 8*a ^ a
  function automatic logic [7:0] mul_09(input logic [7:0] b, input logic [7:0] x8);
    return x8 ^ b;
  endfunction

  // 11*a = 8*a ^ 2*a ^ a
  function automatic logic [7:0] mul_0b(input logic [7:0] b, input logic [7:0] x2,
                                        input logic [7:0] x8);
    return x8 ^ x2 ^ b;
  endfunction

  // 13*a = 8*a ^ 4*a ^ a
  function automatic logic [7:0] mul_0d(input logic [7:0] b, input logic [7:0] x4,
                                        input logic [7:0] x8);
    return x8 ^ x4 ^ b;
  endfunction

  // 14*a = 8*a ^ 4*a ^ 2*a
  function automatic logic [7:0] mul_0e(input logic [7:0] x2, input logic [7:0] x4,
                                        input logic [7:0] x8);
    return x8 ^ x4 ^ x2;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------

  // Handshake terms
  logic             accept_s;    // upstream beat taken into S1 this cycle
  logic             s2_load_s;   // S1 beat moves into S2 this cycle
  logic             out_fire_s;  // downstream handshake this cycle

  // Stage-1 next-state values (input bytes and their xtime multiples)
  logic [7:0]       b_d  [16];
  logic [7:0]       x2_d [16];
  logic [7:0]       x4_d [16];
  logic [7:0]       x8_d [16];

  // Stage-1 registers
  logic             s1_v_q;
  logic             s1_enc_q;
  logic             s1_byp_q;
  logic [7:0]       s1_b_q  [16];
  logic [7:0]       s1_x2_q [16];
  logic [7:0]       s1_x4_q [16];
  logic [7:0]       s1_x8_q [16];

  // Stage-2 next-state value and registers
  logic [7:0]       mix_s [16];
  logic [127:0]     out_data_d;
  logic [127:0]     out_data_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] blk_cnt_q;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------

  // S2 can take the S1 beat when it is empty or is being drained this cycle.
  assign s2_load_s  = s1_v_q && (!out_valid_q || out_ready);
  // S1 can take a new beat when it is empty or is handing its beat to S2.
  assign in_ready   = !s1_v_q || s2_load_s;
  assign accept_s   = in_valid && in_ready;
  assign out_fire_s = out_valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // Stage-1 datapath: unpack the bytes and precompute the xtime chain
  // ---------------------------------------------------------------------------

  for (genvar k = 0; k < 16; k++) begin : g_s1_byte
    assign b_d[k]  = in_data[127 - 8*k -: 8];
    assign x2_d[k] = xtime(b_d[k]);
    assign x4_d[k] = xtime(x2_d[k]);
    assign x8_d[k] = xtime(x4_d[k]);
  end

  // Stage-1 occupancy: set on accept, cleared when the beat leaves without a
  // replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
    end else if (accept_s) begin
      s1_v_q <= 1'b1;
    end else if (s2_load_s) begin
      s1_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_q;
    end
  end

  // Stage-1 payload: loads only on accept, so idle inputs never enter the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_enc_q <= 1'b0;
      s1_byp_q <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        s1_b_q[k]  <= 8'h00;
        s1_x2_q[k] <= 8'h00;
        s1_x4_q[k] <= 8'h00;
        s1_x8_q[k] <= 8'h00;
      end
    end else if (accept_s) begin
      s1_enc_q <= in_enc_en;
      s1_byp_q <= in_bypass;
      for (int k = 0; k < 16; k++) begin
        s1_b_q[k]  <= b_d[k];
        s1_x2_q[k] <= x2_d[k];
        s1_x4_q[k] <= x4_d[k];
        s1_x8_q[k] <= x8_d[k];
      end
    end else begin
      s1_enc_q <= s1_enc_q;
      s1_byp_q <= s1_byp_q;
      for (int k = 0; k < 16; k++) begin
        s1_b_q[k]  <= s1_b_q[k];
        s1_x2_q[k] <= s1_x2_q[k];
        s1_x4_q[k] <= s1_x4_q[k];
        s1_x8_q[k] <= s1_x8_q[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-2 datapath: column mixing from the registered multiples
  // ---------------------------------------------------------------------------

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Column byte indices for a_r, a_{r+1}, a_{r+2}, a_{r+3}, taken mod 4.
      localparam int I0 = 4*c + r;
      localparam int I1 = 4*c + ((r + 1) % 4);
      localparam int I2 = 4*c + ((r + 2) % 4);
      localparam int I3 = 4*c + ((r + 3) % 4);

      logic [7:0] enc_s;
      logic [7:0] dec_s;

      // MixColumns row: 2 3 1 1
      assign enc_s = s1_x2_q[I0]
                   ^ mul_03(s1_b_q[I1], s1_x2_q[I1])
                   ^ s1_b_q[I2]
                   ^ s1_b_q[I3];

      // InvMixColumns row: 0E 0B 0D 09
      assign dec_s = mul_0e(s1_x2_q[I0], s1_x4_q[I0], s1_x8_q[I0])
                   ^ mul_0b(s1_b_q[I1], s1_x2_q[I1], s1_x8_q[I1])
                   ^ mul_0d(s1_b_q[I2], s1_x4_q[I2], s1_x8_q[I2])
                   ^ mul_09(s1_b_q[I3], s1_x8_q[I3]);

      // Bypass takes priority over the mode flag.
      assign mix_s[I0] = s1_byp_q ? s1_b_q[I0] : (s1_enc_q ? enc_s : dec_s);
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_s2_pack
    assign out_data_d[127 - 8*k -: 8] = mix_s[k];
  end

  // Output register: loads on s2_load, empties on a handshake with no refill,
  // and holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 128'd0;
    end else if (s2_load_s) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
    end else if (out_fire_s) begin
      out_valid_q <= 1'b0;
      out_data_q  <= out_data_q;
    end else begin
      out_valid_q <= out_valid_q;
      out_data_q  <= out_data_q;
    end
  end

  // Completed-block counter: one step per output handshake, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= {CNT_W{1'b0}};
    end else if (out_fire_s) begin
      blk_cnt_q <= blk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      blk_cnt_q <= blk_cnt_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_mix_columns_stage.sv
// tb_mix_columns_stage
// Self-checking bench for mix_columns_stage. A GF(2^8) matrix-multiply model
// predicts every output beat, and a scoreboard queue follows the beats that
// are in flight. Directed vectors come from FIPS-197. The design is built with
// a 4-bit block counter so that counter wrap can be exercised.

module tb_mix_columns_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             in_enc_en;
  logic             in_bypass;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [CNT_W-1:0] blk_cnt;

  mix_columns_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_enc_en (in_enc_en),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .blk_cnt   (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [127:0]     exp_q[$];   // expected outputs of beats in flight
  int               out_cyc[$]; // cycle numbers of output handshakes
  logic [CNT_W-1:0] exp_cnt;
  logic             prev_stall;
  logic [127:0]     prev_data;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // General GF(2^8) multiply, polynomial 0x11B (shift-and-add).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Reference: each column is multiplied by the circulant (Inv)MixColumns matrix.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic enc,
                                           input logic byp);
    logic [7:0]   a [16];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (byp) return s;
    if (enc) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    for (int k = 0; k < 16; k++) a[k] = s[127 - 8*k -: 8];
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[j], a[4*c + ((r + j) % 4)]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor and scoreboard. Sampling happens on the falling edge, midway
  // between active edges.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_blk_cnt", {{(128-CNT_W){1'b0}}, blk_cnt}, 128'd0);
      exp_q.delete();
      exp_cnt    = '0;
      prev_stall = 1'b0;
      prev_data  = 128'd0;
    end else begin
      chk("in_ready", {127'd0, in_ready}, {127'd0, (exp_q.size() < 2) || out_ready});
      chk("blk_cnt", {{(128-CNT_W){1'b0}}, blk_cnt}, {{(128-CNT_W){1'b0}}, exp_cnt});
      if (exp_q.size() == 0) chk("spurious_valid", {127'd0, out_valid}, 128'd0);
      if (prev_stall) begin
        chk("stall_valid", {127'd0, out_valid}, 128'd1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mix(in_data, in_enc_en, in_bypass));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Present one beat and hold it until it is accepted. Returns just after the
  // accepting edge.
  task automatic drive_beat(input logic [127:0] d, input logic enc, input logic byp);
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    in_enc_en = enc;
    in_bypass = byp;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
  endtask

  // Send one beat into an idle pipe and compare the result with a constant.
  task automatic xfer(input string tag, input logic [127:0] d, input logic enc,
                      input logic byp, input logic [127:0] exp);
    int n;
    out_ready = 1'b1;
    drive_beat(d, enc, byp);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_data, exp);
    @(posedge clk);
    #1;
  endtask

  // Let the pipe empty with the output side always ready.
  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 128'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    in_enc_en = 1'b0;
    in_bypass = 1'b0;
    out_ready = 1'b0;

    // Reset with random activity on the inputs.
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rand128();
      in_enc_en = 1'($urandom_range(0, 1));
      in_bypass = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;

    // Encrypt vector, with the exact two-cycle latency checked.
    drive_beat(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 1'b0);
    in_valid = 1'b0;
    in_data  = rand128();
    @(negedge clk);
    chk("enc_lat_n1", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    chk("enc_lat_n2", {127'd0, out_valid}, 128'd1);
    chk("enc_vector", out_data, 128'h046681e5e0cb199a48f8d37a2806264c);
    @(negedge clk);
    chk("enc_blk_cnt", {{(128-CNT_W){1'b0}}, blk_cnt}, 128'd1);
    @(posedge clk);
    #1;

    // Decrypt round trip and single-column vectors.
    xfer("dec_vector", 128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 1'b0,
         128'hd4bf5d30e0b452aeb84111f11e2798e5);
    xfer("col_db135345", {4{32'hdb135345}}, 1'b1, 1'b0, {4{32'h8e4da1bc}});
    xfer("col_01_enc", {4{32'h01010101}}, 1'b1, 1'b0, {4{32'h01010101}});
    xfer("col_01_dec", {4{32'h01010101}}, 1'b0, 1'b0, {4{32'h01010101}});
    xfer("bypass_dec_flag", 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1,
         128'h00112233445566778899aabbccddeeff);

    // Four back-to-back beats: enc, dec, bypass, enc.
    out_cyc.delete();
    drive_beat(rand128(), 1'b1, 1'b0);
    drive_beat(rand128(), 1'b0, 1'b0);
    drive_beat(rand128(), 1'($urandom_range(0, 1)), 1'b1);
    drive_beat(rand128(), 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("stream_count", out_cyc.size(), 128'd4);
    chk("stream_span", out_cyc[3] - out_cyc[0], 128'd3);
    @(posedge clk);
    #1;

    // Six beats with out_ready low for cycles 3..7.
    out_cyc.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) drive_beat(rand128(), 1'($urandom_range(0, 1)), 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 14; t++) begin
          out_ready = !(t >= 3 && t <= 7);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    chk("bp_count", out_cyc.size(), 128'd6);

    // Random traffic with random gaps and random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            in_data = rand128();
            @(posedge clk);
            #1;
          end
          drive_beat(rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    // Reset while two beats are in flight: neither may come out afterwards.
    out_ready = 1'b0;
    drive_beat(rand128(), 1'b1, 1'b0);
    drive_beat(rand128(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_out_after_rst", {127'd0, out_valid}, 128'd0);
    end
    @(posedge clk);
    #1;

    // Seventeen beats wrap the 4-bit block counter to 1.
    for (int i = 0; i < 17; i++) drive_beat(rand128(), 1'($urandom_range(0, 1)), 1'b0);
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("cnt_wrap", {{(128-CNT_W){1'b0}}, blk_cnt}, 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
